// File: rtl/udp_parser_pkg.sv
// Shared types and constants for the UDP order parser.
// Purpose: parser state enum, header match constants, default opcodes, order field layout.
// Ports: none (package).
package udp_parser_pkg;

  typedef enum logic [2:0] {
    HDR,
    OPCODE,
    PAYLOAD_MKT,
    PAYLOAD_DUMP,
    DROP
  } state_e;

  // Header match constants and the byte offsets they live at
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
  localparam logic [15:0] OFF_ETYPE      = 16'd12;
  localparam logic [15:0] OFF_PROTO      = 16'd23;
  localparam logic [15:0] OFF_DIP        = 16'd30;
  localparam logic [15:0] OFF_SPORT      = 16'd34;

  localparam logic [23:0] DEF_OP_MARKET  = 24'h102030;
  localparam logic [23:0] DEF_OP_DUMP    = 24'hF0E0D0;

  // 32-bit order word layout: price [31:16], is_buy [15], is_bot [14], qty [13:0]
  typedef struct packed {
    logic [15:0] price;
    logic        is_buy;
    logic        is_bot;
    logic [13:0] qty;
  } order_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/udp_order_parser_if.sv
// AXI-stream style bundle used for the byte input and the order output.
// Purpose: tdata/tvalid/tlast forward, tready backward; width set by DW.
// Ports: master drives tdata/tvalid/tlast and samples tready; slave the reverse.
interface udp_order_parser_if #(
  parameter int DW = 8
) ();
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic          tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/udp_hdr_filter.sv
// Header filter: flags EtherType, protocol, destination IP or source port mismatch.
// Latency: mismatch_o includes the current byte combinationally; sticky part is registered.
// Backpressure: none; only observes accepted bytes (vld_i). Ports: clk/rst, idx_i, data_i, vld_i, mismatch_o.
module udp_hdr_filter
  import udp_parser_pkg::*;
#(
  parameter logic [31:0] DEST_IP  = 32'hC0A80132,
  parameter logic [15:0] SRC_PORT = 16'd55555
) (
  input  logic        clk_udp,
  input  logic        rst_udp,
  input  logic [15:0] idx_i,
  input  logic [7:0]  data_i,
  input  logic        vld_i,
  output logic        mismatch_o
);

  logic       mismatch_q, mismatch_d;
  logic       chk;
  logic [7:0] exp_byte;
  logic       bad;
  logic       carried;

  always_comb begin
    chk      = 1'b1;
    exp_byte = 8'h00;
    case (idx_i)
      OFF_ETYPE:          exp_byte = ETHERTYPE_IPV4[15:8];
      OFF_ETYPE + 16'd1:  exp_byte = ETHERTYPE_IPV4[7:0];
      OFF_PROTO:          exp_byte = IP_PROTO_UDP;
      OFF_DIP:            exp_byte = DEST_IP[31:24];
      OFF_DIP + 16'd1:    exp_byte = DEST_IP[23:16];
      OFF_DIP + 16'd2:    exp_byte = DEST_IP[15:8];
      OFF_DIP + 16'd3:    exp_byte = DEST_IP[7:0];
      OFF_SPORT:          exp_byte = SRC_PORT[15:8];
      OFF_SPORT + 16'd1:  exp_byte = SRC_PORT[7:0];
      default:            chk      = 1'b0;
    endcase
  end

  assign bad        = vld_i && chk && (data_i != exp_byte);
  // Byte 0 of a frame starts from a clean flag, whatever the previous frame left behind
  assign carried    = (idx_i == 16'd0) ? 1'b0 : mismatch_q;
  assign mismatch_o = carried | bad;
  assign mismatch_d = vld_i ? (carried | bad) : mismatch_q;

  always_ff @(posedge clk_udp or posedge rst_udp) begin
    if (rst_udp) mismatch_q <= 1'b0;
    else         mismatch_q <= mismatch_d;
  end

endmodule

// File: rtl/udp_order_parser.sv
// UDP-to-order front end: filters Ethernet/IPv4/UDP frames, decodes opcode, emits order words or dump pulses.
// Latency: order valid the cycle after its last byte; dump_req and counters the cycle after tlast.
// Backpressure: s_axis.tready drops only when the next byte would complete an order and the held order is unaccepted.
// Ports: clk_udp, rst_udp, s_axis (8-bit slave), m_order (ORDER_BYTES*8 master), dump_req, frames_ok, frames_dropped.
module udp_order_parser
  import udp_parser_pkg::*;
#(
  parameter logic [31:0] DEST_IP     = 32'hC0A80132,
  parameter logic [15:0] SRC_PORT    = 16'd55555,
  parameter logic [23:0] OP_MARKET   = DEF_OP_MARKET,
  parameter logic [23:0] OP_DUMP     = DEF_OP_DUMP,
  parameter int          ORDER_BYTES = 4,
  parameter int          HDR_BYTES   = 42,
  parameter int          MAX_ORDERS  = 16
) (
  input  logic                clk_udp,
  input  logic                rst_udp,
  udp_order_parser_if.slave   s_axis,
  udp_order_parser_if.master  m_order,
  output logic                dump_req,
  output logic [15:0]         frames_ok,
  output logic [15:0]         frames_dropped
);

  localparam int OW  = ORDER_BYTES * 8;
  localparam int BCW = $clog2(ORDER_BYTES);
  localparam int OCW = $clog2(MAX_ORDERS + 1);
  localparam logic [BCW-1:0] BC_LAST      = BCW'(ORDER_BYTES - 1);
  localparam logic [OCW-1:0] OC_MAX       = OCW'(MAX_ORDERS);
  localparam logic [15:0]    IDX_HDR_LAST = 16'(HDR_BYTES - 1);
  localparam logic [15:0]    IDX_OP_LAST  = 16'(HDR_BYTES + 2);

  state_e          state_q, state_d;
  logic [15:0]     idx_q, idx_d;
  logic [15:0]     op_q, op_d;
  logic [BCW-1:0]  bcnt_q, bcnt_d;
  logic [OCW-1:0]  ocnt_q, ocnt_d;
  logic [OW-9:0]   asm_q, asm_d;
  logic [OW-1:0]   out_q, out_d;
  logic            out_vld_q, out_vld_d;
  logic            out_last_q, out_last_d;
  logic            dump_q, dump_d;
  logic [15:0]     ok_q, ok_d, drop_q, drop_d;

  logic            s_rdy, beat, hdr_bad;
  logic            ok_inc, drop_inc, dump_inc, load;
  logic [23:0]     op_full;
  logic [OW-1:0]   word;

  udp_hdr_filter #(
    .DEST_IP  (DEST_IP),
    .SRC_PORT (SRC_PORT)
  ) u_hdr_filter (
    .clk_udp    (clk_udp),
    .rst_udp    (rst_udp),
    .idx_i      (idx_q),
    .data_i     (s_axis.tdata),
    .vld_i      (beat && (state_q == HDR)),
    .mismatch_o (hdr_bad)
  );

  // Stall only the byte that would overwrite an order still waiting downstream
  assign s_rdy   = !((state_q == PAYLOAD_MKT) && (bcnt_q == BC_LAST) &&
                     out_vld_q && !m_order.tready);
  assign beat    = s_axis.tvalid && s_rdy;
  assign op_full = {op_q, s_axis.tdata};
  assign word    = {asm_q, s_axis.tdata};

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    op_d       = op_q;
    bcnt_d     = bcnt_q;
    ocnt_d     = ocnt_q;
    asm_d      = asm_q;
    out_d      = out_q;
    out_last_d = out_last_q;
    ok_inc     = 1'b0;
    drop_inc   = 1'b0;
    dump_inc   = 1'b0;
    load       = 1'b0;

    if (beat) begin
      idx_d = s_axis.tlast ? 16'd0 : sat_inc16(idx_q);
      case (state_q)
        HDR: begin
          if (s_axis.tlast)                drop_inc = 1'b1;
          else if (idx_q == IDX_HDR_LAST) state_d  = hdr_bad ? DROP : OPCODE;
        end
        OPCODE: begin
          op_d = op_full[15:0];
          if (idx_q == IDX_OP_LAST) begin
            bcnt_d = '0;
            ocnt_d = '0;
            // tlast on the final opcode byte means an empty payload
            if (op_full == OP_MARKET) begin
              if (s_axis.tlast) ok_inc = 1'b1;
              else              state_d = PAYLOAD_MKT;
            end else if (op_full == OP_DUMP) begin
              if (s_axis.tlast) begin
                dump_inc = 1'b1;
                ok_inc   = 1'b1;
              end else begin
                state_d = PAYLOAD_DUMP;
              end
            end else begin
              if (s_axis.tlast) drop_inc = 1'b1;
              else              state_d  = DROP;
            end
          end else if (s_axis.tlast) begin
            drop_inc = 1'b1;
          end
        end
        PAYLOAD_MKT: begin
          if (bcnt_q == BC_LAST) begin
            bcnt_d = '0;
            if (ocnt_q == OC_MAX) begin
              // over the per-frame limit: suppress and discard the rest
              state_d = DROP;
              if (s_axis.tlast) drop_inc = 1'b1;
            end else begin
              load       = 1'b1;
              out_d      = word;
              out_last_d = s_axis.tlast;
              ocnt_d     = ocnt_q + OCW'(1);
              if (s_axis.tlast) ok_inc = 1'b1;
            end
          end else begin
            bcnt_d = bcnt_q + BCW'(1);
            asm_d  = word[OW-9:0];
            if (s_axis.tlast) begin
              // a lone byte with no order before it is padding, anything else is truncation
              if ((bcnt_q == '0) && (ocnt_q == '0)) ok_inc   = 1'b1;
              else                                  drop_inc = 1'b1;
            end
          end
        end
        PAYLOAD_DUMP: begin
          if (s_axis.tlast) begin
            dump_inc = 1'b1;
            ok_inc   = 1'b1;
          end
        end
        DROP: begin
          if (s_axis.tlast) drop_inc = 1'b1;
        end
        default: state_d = HDR;
      endcase
      if (s_axis.tlast) state_d = HDR;
    end
  end

  assign out_vld_d = load ? 1'b1 : ((out_vld_q && m_order.tready) ? 1'b0 : out_vld_q);
  assign dump_d    = dump_inc;
  assign ok_d      = ok_inc   ? sat_inc16(ok_q)   : ok_q;
  assign drop_d    = drop_inc ? sat_inc16(drop_q) : drop_q;

  always_ff @(posedge clk_udp or posedge rst_udp) begin
    if (rst_udp) begin
      state_q    <= HDR;
      idx_q      <= 16'd0;
      op_q       <= 16'd0;
      bcnt_q     <= '0;
      ocnt_q     <= '0;
      asm_q      <= '0;
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      dump_q     <= 1'b0;
      ok_q       <= 16'd0;
      drop_q     <= 16'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      op_q       <= op_d;
      bcnt_q     <= bcnt_d;
      ocnt_q     <= ocnt_d;
      asm_q      <= asm_d;
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      out_last_q <= out_last_d;
      dump_q     <= dump_d;
      ok_q       <= ok_d;
      drop_q     <= drop_d;
    end
  end

  assign s_axis.tready  = s_rdy;
  assign m_order.tdata  = out_q;
  assign m_order.tvalid = out_vld_q;
  assign m_order.tlast  = out_last_q;
  assign dump_req       = dump_q;
  assign frames_ok      = ok_q;
  assign frames_dropped = drop_q;

endmodule

// File: tb/tb_udp_order_parser.sv
// Bench for udp_order_parser: directed frames from the test plan, then randomized frames
// checked against a whole-frame reference model (length arithmetic over the byte list).
module tb_udp_order_parser;
  import udp_parser_pkg::*;

  localparam int          OB    = 4;
  localparam int          HB    = 42;
  localparam int          MAXO  = 16;
  localparam logic [31:0] DIP   = 32'hC0A80132;
  localparam logic [15:0] SPORT = 16'd55555;
  localparam logic [23:0] OPM   = 24'h102030;
  localparam logic [23:0] OPD   = 24'hF0E0D0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dump_req;
  logic [15:0] frames_ok, frames_dropped;

  udp_order_parser_if #(.DW(8))      s_if ();
  udp_order_parser_if #(.DW(OB * 8)) m_if ();

  udp_order_parser #(
    .DEST_IP(DIP), .SRC_PORT(SPORT), .OP_MARKET(OPM), .OP_DUMP(OPD),
    .ORDER_BYTES(OB), .HDR_BYTES(HB), .MAX_ORDERS(MAXO)
  ) dut (
    .clk_udp        (clk),
    .rst_udp        (rst),
    .s_axis         (s_if),
    .m_order        (m_if),
    .dump_req       (dump_req),
    .frames_ok      (frames_ok),
    .frames_dropped (frames_dropped)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [7:0]    frm[$];
  logic [OB*8:0] exp_orders[$];   // {tlast, word}
  int            exp_ok = 0, exp_drop = 0, exp_dumps = 0;
  int            dumps_seen = 0, stall_cnt = 0;
  int            rdy_mode = 1;    // 0 random, 1 high, 2 low
  bit            gap_en = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_counters();
    check_eq("frames_ok", frames_ok, 64'(exp_ok));
    check_eq("frames_dropped", frames_dropped, 64'(exp_drop));
    check_eq("dump_count", 64'(dumps_seen), 64'(exp_dumps));
  endtask

  // ---------------- frame construction ----------------
  task automatic new_hdr(input logic [31:0] dip);
    logic [15:0] sp;
    sp = SPORT;
    frm.delete();
    for (int i = 0; i < HB; i++) frm.push_back(8'($urandom_range(0, 255)));
    frm[12] = 8'h08; frm[13] = 8'h00; frm[23] = 8'h11;
    frm[30] = dip[31:24]; frm[31] = dip[23:16]; frm[32] = dip[15:8]; frm[33] = dip[7:0];
    frm[34] = sp[15:8];   frm[35] = sp[7:0];
  endtask

  task automatic add_op(input logic [23:0] op);
    frm.push_back(op[23:16]); frm.push_back(op[15:8]); frm.push_back(op[7:0]);
  endtask

  task automatic add_word(input logic [OB*8-1:0] w);
    for (int i = OB - 1; i >= 0; i--) frm.push_back(w[i*8 +: 8]);
  endtask

  task automatic add_rand(input int n);
    for (int i = 0; i < n; i++) frm.push_back(8'($urandom_range(0, 255)));
  endtask

  // ---------------- reference model over a whole frame ----------------
  task automatic model_frame();
    int len, p, n, r, emit;
    logic [23:0] op;
    logic [OB*8-1:0] w;
    bit hdr_ok;
    len = frm.size();
    if (len <= HB) begin exp_drop++; return; end
    hdr_ok = (frm[12] == 8'h08) && (frm[13] == 8'h00) && (frm[23] == 8'h11) &&
             ({frm[30], frm[31], frm[32], frm[33]} == DIP) && ({frm[34], frm[35]} == SPORT);
    if (!hdr_ok) begin exp_drop++; return; end
    if (len < HB + 3) begin exp_drop++; return; end
    op = {frm[HB], frm[HB+1], frm[HB+2]};
    if (op == OPD) begin exp_ok++; exp_dumps++; return; end
    if (op != OPM) begin exp_drop++; return; end
    p = len - HB - 3;
    n = p / OB;
    r = p % OB;
    emit = (n > MAXO) ? MAXO : n;
    for (int k = 0; k < emit; k++) begin
      w = '0;
      for (int j = 0; j < OB; j++) w = {w[OB*8-9:0], frm[HB + 3 + k*OB + j]};
      exp_orders.push_back({(k == n - 1) && (r == 0) && (n <= MAXO), w});
    end
    if (n > MAXO)              exp_drop++;
    else if (r == 0)           exp_ok++;
    else if (r == 1 && n == 0) exp_ok++;
    else                       exp_drop++;
  endtask

  // ---------------- driver ----------------
  task automatic send_frm(input bit end_last);
    int budget;
    bit acc;
    for (int i = 0; i < frm.size(); i++) begin
      if (gap_en && $urandom_range(0, 3) == 0) begin
        s_if.tvalid = 1'b0;
        @(posedge clk); #1;
      end
      s_if.tdata  = frm[i];
      s_if.tlast  = end_last && (i == frm.size() - 1);
      s_if.tvalid = 1'b1;
      budget = 0;
      acc    = 1'b0;
      while (!acc && budget < 2000) begin
        @(negedge clk);
        acc = s_if.tready;
        @(posedge clk); #1;
        budget++;
      end
      if (!acc) begin
        check_eq("s_tready_timeout", 0, 1);
        break;
      end
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic finish_frame();
    repeat (2) @(posedge clk);
    #1;
    check_counters();
  endtask

  // ---------------- downstream ready ----------------
  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_if.tready = ($urandom_range(0, 2) != 0);
        1:       m_if.tready = 1'b1;
        default: m_if.tready = 1'b0;
      endcase
    end
  end

  // ---------------- output monitor ----------------
  initial begin
    logic [OB*8:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (m_if.tvalid && m_if.tready) begin
          if (exp_orders.size() == 0) begin
            check_eq("order_unexpected", m_if.tdata, 0);
          end else begin
            e = exp_orders.pop_front();
            check_eq("order_data", m_if.tdata, e[OB*8-1:0]);
            check_eq("order_last", m_if.tlast, e[OB*8]);
          end
        end
        if (dump_req) dumps_seen++;
        if (s_if.tvalid && !s_if.tready) stall_cnt++;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    order_t o1, o2, o3;
    int kind, n, r, pos, L, stall_base;
    logic [23:0] op;

    s_if.tdata = 8'h00; s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_s_tready", s_if.tready, 1);
    check_eq("rst_m_tvalid", m_if.tvalid, 0);
    check_eq("rst_m_tlast", m_if.tlast, 0);
    check_eq("rst_m_tdata", m_if.tdata, 0);
    check_eq("rst_dump_req", dump_req, 0);
    check_counters();
    rst = 1'b0;
    @(posedge clk); #1;

    // one market order {price 105, sell, not bot, qty 10}
    o1 = '{price: 16'd105, is_buy: 1'b0, is_bot: 1'b0, qty: 14'd10};
    new_hdr(DIP); add_op(OPM); add_word(o1);
    exp_orders.push_back({1'b1, 32'h0069000A}); exp_ok++;
    send_frm(1); finish_frame();

    // wrong destination IP
    new_hdr(32'hC0A80133); add_op(OPM); add_word(o1);
    exp_drop++;
    send_frm(1); finish_frame();

    // dump with one padding byte
    new_hdr(DIP); add_op(OPD); frm.push_back(8'h00);
    exp_dumps++; exp_ok++;
    send_frm(1); finish_frame();

    // three orders with the output held off: input must stall, orders arrive intact
    o1 = '{price: 16'd200, is_buy: 1'b1, is_bot: 1'b0, qty: 14'd5};
    o2 = '{price: 16'd201, is_buy: 1'b0, is_bot: 1'b1, qty: 14'd7};
    o3 = '{price: 16'hFFFF, is_buy: 1'b1, is_bot: 1'b1, qty: 14'h3FFF};
    new_hdr(DIP); add_op(OPM); add_word(o1); add_word(o2); add_word(o3);
    exp_orders.push_back({1'b0, 32'h00C88005});
    exp_orders.push_back({1'b0, 32'h00C94007});
    exp_orders.push_back({1'b1, 32'hFFFFFFFF});
    exp_ok++;
    stall_base = stall_cnt;
    rdy_mode = 2;
    fork
      send_frm(1);
      begin
        int b;
        b = 0;
        while (stall_cnt == stall_base && b < 500) begin @(posedge clk); b++; end
        repeat (20) @(posedge clk);
        @(negedge clk);
        check_eq("stall_held", s_if.tready, 0);
        rdy_mode = 1;
      end
    join
    check_eq("stall_seen", 64'(stall_cnt > stall_base), 1);
    finish_frame();
    repeat (5) @(posedge clk); #1;
    check_eq("stall_orders_left", 64'(exp_orders.size()), 0);

    // truncated inside the second order, then a clean frame
    new_hdr(DIP); add_op(OPM); add_word(32'h12345678); add_rand(2);
    exp_orders.push_back({1'b0, 32'h12345678}); exp_drop++;
    send_frm(1); finish_frame();
    new_hdr(DIP); add_op(OPM); add_word(32'h0BADCAFE);
    exp_orders.push_back({1'b1, 32'h0BADCAFE}); exp_ok++;
    send_frm(1); finish_frame();

    // reset in the middle of a payload with an order held in the output register
    repeat (5) @(posedge clk); #1;
    rdy_mode = 2;
    new_hdr(DIP); add_op(OPM); add_word(32'hA5A5A5A5); add_rand(1);
    send_frm(0);
    repeat (2) @(posedge clk); #1;
    check_eq("pre_reset_vld", m_if.tvalid, 1);
    rst = 1'b1;
    #1;
    check_eq("midrst_s_tready", s_if.tready, 1);
    check_eq("midrst_m_tvalid", m_if.tvalid, 0);
    check_eq("midrst_m_tdata", m_if.tdata, 0);
    check_eq("midrst_ok", frames_ok, 0);
    check_eq("midrst_drop", frames_dropped, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    rdy_mode = 1;
    exp_ok = 0; exp_drop = 0;
    frm.delete(); add_rand(3);
    exp_drop++;
    send_frm(1); finish_frame();
    new_hdr(DIP); add_op(OPM); add_word(32'h00640003);
    exp_orders.push_back({1'b1, 32'h00640003}); exp_ok++;
    send_frm(1); finish_frame();

    // randomized frames against the reference model
    gap_en   = 1'b1;
    rdy_mode = 0;
    for (int f = 0; f < 60; f++) begin
      kind = $urandom_range(0, 10);
      n = $urandom_range(0, 4);
      if ($urandom_range(0, 4) == 0) n = $urandom_range(14, 18);
      if (n == 0) r = $urandom_range(1, OB - 1);
      else begin
        r = $urandom_range(0, OB - 1);
        if (r == 1) r = 0;
      end
      op = OPM;
      if (kind == 4) op = OPD;
      if (kind == 9) begin
        op = 24'($urandom());
        if (op == OPM || op == OPD) op = 24'h000001;
      end
      new_hdr(DIP); add_op(op);
      if (kind == 4) add_rand($urandom_range(1, 6));
      else           add_rand(n * OB + r);
      pos = -1;
      case (kind)
        5: pos = 12 + $urandom_range(0, 1);
        6: pos = 23;
        7: pos = 30 + $urandom_range(0, 3);
        8: pos = 34 + $urandom_range(0, 1);
        default: ;
      endcase
      if (pos >= 0) frm[pos] = frm[pos] ^ 8'($urandom_range(1, 255));
      if (kind == 10) begin
        L = $urandom_range(1, HB + 2);
        while (frm.size() > L) void'(frm.pop_back());
      end
      model_frame();
      send_frm(1);
      finish_frame();
    end

    gap_en   = 1'b0;
    rdy_mode = 1;
    repeat (50) @(posedge clk); #1;
    check_eq("orders_left", 64'(exp_orders.size()), 0);
    check_counters();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
